div_unit: RTL and testbench

Iterative radix-2 integer divider implementing RV64 DIV/DIVU/REM/REMU. It sits downstream of the register file: it consumes the two read-port operands and returns its result through the register-file write port. While the divider is busy the core stalls. The destination register tag travels with the operation so the block can drive the writeback strobe directly.

---
 rtl/div_unit_pkg.sv | 30 +++
 rtl/div_special_detect.sv | 37 +++
 rtl/div_unit.sv | 169 ++++++++++++++++
 tb/tb_div_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_pkg
// Purpose  : Shared widths and RV64 M-extension divide op encodings.
// Revision : 1.0  initial release
// ============================================================================
package div_unit_pkg;

    localparam int          DataBusBits = 64;
    localparam int          RegAddrBits = 5;
    localparam logic [63:0] DataZero    = 64'd0;

    typedef logic [1:0] div_op_t;

    localparam div_op_t OP_DIV  = 2'b00;
    localparam div_op_t OP_DIVU = 2'b01;
    localparam div_op_t OP_REM  = 2'b10;
    localparam div_op_t OP_REMU = 2'b11;

    // Bit 0 of the encoding marks unsigned ops, bit 1 selects the remainder.
    function automatic logic op_is_signed(input div_op_t op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_special_detect.sv
`default_nettype none
// ============================================================================
// Module   : div_special_detect
// Purpose  : Flags divide-by-zero and signed overflow and forms their result.
// Revision : 1.0  initial release
// ============================================================================
module div_special_detect
    import div_unit_pkg::*;
#(
    parameter int XLEN = DataBusBits
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            is_div0,
    output logic            is_ovf,
    output logic [XLEN-1:0] special_result
);

    localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic w_rem;

    always_comb begin
        w_rem   = op_is_rem(op);
        is_div0 = (operand_b == '0);
        is_ovf  = op_is_signed(op) && (operand_a == c_MIN_NEG) && (&operand_b);
        // Both cases share a shape: quotient is all ones / dividend, remainder dividend / zero.
        if (is_div0) begin
            special_result = w_rem ? operand_a : '1;
        end else begin
            special_result = w_rem ? '0 : operand_a;
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Revision : 1.0  initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = DataBusBits,
    parameter int REGW = RegAddrBits
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [REGW-1:0] rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            wb_we,
    output logic [REGW-1:0] rd_out
);

    localparam int                c_CNTW = $clog2(XLEN);
    localparam logic [c_CNTW-1:0] c_LAST = c_CNTW'(XLEN - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_wb_we;
    logic [XLEN-1:0]   r_result;
    logic [REGW-1:0]   r_rd;
    logic              r_is_rem;
    logic              r_qsign;
    logic              r_rsign;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic [c_CNTW-1:0] r_cnt;

    logic              w_is_div0;
    logic              w_is_ovf;
    logic [XLEN-1:0]   w_spec_result;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    div_special_detect #(
        .XLEN (XLEN)
    ) u_special (
        .op             (op),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .is_div0        (w_is_div0),
        .is_ovf         (w_is_ovf),
        .special_result (w_spec_result)
    );

    always_comb begin
        w_sign_a  = op_is_signed(op) && operand_a[XLEN-1];
        w_sign_b  = op_is_signed(op) && operand_b[XLEN-1];
        w_abs_a   = w_sign_a ? -operand_a : operand_a;
        w_abs_b   = w_sign_b ? -operand_b : operand_b;
        // The partial remainder is always below the divisor, so one extra bit covers the shift.
        w_shift   = {r_rem, r_quo[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_dvs};
        w_quo_fix = r_qsign ? -r_quo : r_quo;
        w_rem_fix = r_rsign ? -r_rem : r_rem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wb_we  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
            r_is_rem <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
        end else begin
            r_done  <= 1'b0;
            r_wb_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start && !flush) begin
                        r_rd     <= rd_in;
                        r_is_rem <= op_is_rem(op);
                        r_busy   <= 1'b1;
                        if (w_is_div0 || w_is_ovf) begin
                            r_result <= w_spec_result;
                            r_done   <= 1'b1;
                            r_wb_we  <= (rd_in != '0);
                            r_state  <= c_DONE;
                        end else begin
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_qsign <= w_sign_a ^ w_sign_b;
                            r_rsign <= w_sign_a;
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        if (!w_diff[XLEN]) begin
                            r_rem <= w_diff[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[XLEN-1:0];
                            r_quo <= {r_quo[XLEN-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_FIX;
                        end
                    end
                end
                c_FIX: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end else begin
                        r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
                        r_done   <= 1'b1;
                        r_wb_we  <= (r_rd != '0);
                        r_state  <= c_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign wb_we  = r_wb_we;
    assign result = r_result;
    assign rd_out = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Scoreboard bench for div_unit covering normal, special and control cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_unit;

    localparam int XLEN = 64;
    localparam int REGW = 5;
    localparam int c_NORM_LAT = XLEN + 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [REGW-1:0] rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            wb_we;
    logic [REGW-1:0] rd_out;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [REGW-1:0] rd;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_unit #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .wb_we     (wb_we),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent RISC-V divide semantics.
    function automatic logic [XLEN-1:0] ref_div(input logic [1:0] o, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sd;
        sa = a;
        sd = b;
        if (b == '0) return o[1] ? a : '1;
        if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) return o[1] ? '0 : a;
        case (o)
            2'b00:   return sa / sd;
            2'b01:   return a / b;
            2'b10:   return sa % sd;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (b == '0) return 1;
        if (!o[0] && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return c_NORM_LAT;
    endfunction

    task automatic push_exp(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [REGW-1:0] rd);
        exp_t e;
        e.res = ref_div(o, a, b);
        e.rd  = rd;
        e.lat = ref_lat(o, a, b);
        sb.push_back(e);
    endtask

    // Called at the negedge where the accepted start cycle count n applies.
    task automatic wait_and_check(input int n_in);
        exp_t e;
        int   n;
        n = n_in;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (!done) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            chk("result", result, e.res);
            chk("rd_out", {{(XLEN-REGW){1'b0}}, rd_out}, {{(XLEN-REGW){1'b0}}, e.rd});
            chk("wb_we", {63'd0, wb_we}, {63'd0, e.rd != '0});
            chk("latency", 64'(n), 64'(e.lat));
        end
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd0);
        chk("busy_after", {63'd0, busy}, 64'd0);
    endtask

    task automatic drive_start(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [REGW-1:0] rd);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [REGW-1:0] rd);
        push_exp(o, a, b, rd);
        @(negedge clk);
        drive_start(o, a, b, rd);
        @(negedge clk);
        start = 1'b0;
        wait_and_check(1);
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        operand_a = '0;
        operand_b = '0;
        rd_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_wb_we", {63'd0, wb_we}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_rd_out", {59'd0, rd_out}, 64'd0);
        reset = 1'b0;

        run_op(2'b01, 64'd100, 64'd7, 5'd5);
        run_op(2'b00, -64'sd7, 64'd2, 5'd6);
        run_op(2'b10, -64'sd7, 64'd2, 5'd7);
        run_op(2'b00, 64'd5, 64'd0, 5'd8);
        run_op(2'b11, 64'd5, 64'd0, 5'd9);
        run_op(2'b00, 64'h8000_0000_0000_0000, '1, 5'd10);
        run_op(2'b10, 64'h8000_0000_0000_0000, '1, 5'd11);
        run_op(2'b01, 64'd9, 64'd3, 5'd0);
        for (int i = 0; i < 4; i++) begin
            run_op(2'(i), {$urandom, $urandom}, {32'd0, $urandom} | 64'd1, 5'(i + 12));
        end

        // A start while busy must be ignored.
        push_exp(2'b01, 64'd100, 64'd7, 5'd5);
        @(negedge clk);
        drive_start(2'b01, 64'd100, 64'd7, 5'd5);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (9) begin
            @(negedge clk);
            n++;
        end
        chk("busy_mid", {63'd0, busy}, 64'd1);
        drive_start(2'b00, 64'd5, 64'd0, 5'd3);
        @(negedge clk);
        n++;
        start = 1'b0;
        wait_and_check(n);

        // Flush mid-CALC: no done, result keeps the last value (14).
        @(negedge clk);
        drive_start(2'b01, 64'd200, 64'd3, 5'd4);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_result", result, 64'd14);
        seen = 0;
        repeat (80) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(seen), 64'd0);

        // Flush and start together in IDLE: start not accepted.
        drive_start(2'b01, 64'd9, 64'd3, 5'd2);
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);

        // Reset mid-CALC.
        @(negedge clk);
        drive_start(2'b01, 64'd100, 64'd7, 5'd5);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_rd_out", {59'd0, rd_out}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);

        run_op(2'b01, 64'd9, 64'd3, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
